// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer and run controller for the single-cycle core
module pc_sequencer #(
  parameter int PCW        = 10,
  parameter int OFFW       = 6,
  parameter int START_ADDR = 0,
  parameter int CNTW       = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Branch,
  input  logic            absj,
  input  logic            Taken,
  input  logic [PCW-1:0]  Target,
  input  logic [OFFW-1:0] Offset,
  input  logic            Halt,
  input  logic            Stall,
  output logic [PCW-1:0]  ProgCtr,
  output logic            Busy,
  output logic            Done,
  output logic [CNTW-1:0] CycleCount
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state;
  logic [PCW-1:0]  seq_pc;
  logic [PCW-1:0]  rel_pc;
  logic [PCW-1:0]  off_ext;
  logic [CNTW-1:0] cnt_next;

  // Candidate next PCs and the saturating counter step; additions wrap modulo 2**PCW
  always_comb begin
    off_ext  = {{(PCW-OFFW){Offset[OFFW-1]}}, Offset};
    seq_pc   = ProgCtr + PCW'(1);
    rel_pc   = ProgCtr + off_ext;
    cnt_next = (CycleCount == {CNTW{1'b1}}) ? CycleCount : CycleCount + CNTW'(1);
  end

  // Run-control FSM; Stall beats Halt beats Branch beats sequential fetch
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      CycleCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state      <= RUN;
            ProgCtr    <= PCW'(START_ADDR);
            Busy       <= 1'b1;
            CycleCount <= '0;
          end
        end
        RUN: begin
          CycleCount <= cnt_next;
          if (Stall) begin
            ProgCtr <= ProgCtr;
          end else if (Halt) begin
            state <= HALT;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else if (Branch && Taken) begin
            ProgCtr <= absj ? Target : rel_pc;
          end else begin
            ProgCtr <= seq_pc;
          end
        end
        HALT: begin
          // PC and counter stay frozen so the last run can be read back
          if (!Start) begin
            state <= IDLE;
            Done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int PCW  = 10;
  localparam int OFFW = 6;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            Start = 1'b0;
  logic            Branch = 1'b0;
  logic            absj = 1'b0;
  logic            Taken = 1'b0;
  logic [PCW-1:0]  Target = '0;
  logic [OFFW-1:0] Offset = '0;
  logic            Halt = 1'b0;
  logic            Stall = 1'b0;
  logic [PCW-1:0]  ProgCtr, ProgCtr4;
  logic            Busy, Done, Busy4, Done4;
  logic [15:0]     CycleCount;
  logic [3:0]      CycleCount4;

  always #5 Clk = ~Clk;

  pc_sequencer #(.PCW(PCW), .OFFW(OFFW), .START_ADDR(0), .CNTW(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .absj(absj),
    .Taken(Taken), .Target(Target), .Offset(Offset), .Halt(Halt), .Stall(Stall),
    .ProgCtr(ProgCtr), .Busy(Busy), .Done(Done), .CycleCount(CycleCount)
  );

  pc_sequencer #(.PCW(PCW), .OFFW(OFFW), .START_ADDR(0), .CNTW(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Branch(Branch), .absj(absj),
    .Taken(Taken), .Target(Target), .Offset(Offset), .Halt(Halt), .Stall(Stall),
    .ProgCtr(ProgCtr4), .Busy(Busy4), .Done(Done4), .CycleCount(CycleCount4)
  );

  typedef struct {
    logic            rst, start, br, ab, tk, hlt, stl;
    logic [PCW-1:0]  tgt;
    logic [OFFW-1:0] off;
    int              e_pc, e_busy, e_done, e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int m_pc, m_cnt, m_cnt4;
  bit m_busy, m_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic start, input logic br, input logic ab,
                     input logic tk, input int tgt, input logic [OFFW-1:0] off,
                     input logic hlt, input logic stl,
                     input int pc, input int busy, input int done, input int cnt);
    vec_t v;
    v.rst = rst; v.start = start; v.br = br; v.ab = ab; v.tk = tk;
    v.tgt = PCW'(tgt); v.off = off; v.hlt = hlt; v.stl = stl;
    v.e_pc = pc; v.e_busy = busy; v.e_done = done; v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic start, input logic br, input logic ab,
                       input logic tk, input logic [PCW-1:0] tgt, input logic [OFFW-1:0] off,
                       input logic hlt, input logic stl);
    Reset = rst; Start = start; Branch = br; absj = ab; Taken = tk;
    Target = tgt; Offset = off; Halt = hlt; Stall = stl;
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Behavioural step of the run controller: what one clock edge should do
  task automatic model_step();
    logic signed [OFFW-1:0] soff;
    int step;
    soff = Offset;
    if (Reset) begin
      m_pc = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (!m_busy && !m_done) begin
      if (Start) begin
        m_busy = 1; m_pc = 0; m_cnt = 0; m_cnt4 = 0;
      end
    end else if (m_busy) begin
      m_cnt  = sat(m_cnt + 1, 65535);
      m_cnt4 = sat(m_cnt4 + 1, 15);
      if (Stall) begin
        step = 0;
      end else if (Halt) begin
        m_busy = 0; m_done = 1;
      end else if (Branch && Taken) begin
        if (absj) m_pc = int'(Target);
        else m_pc = ((m_pc + int'(soff)) % 1024 + 1024) % 1024;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end else begin
      if (!Start) m_done = 0;
    end
  endtask

  initial begin
    // rst st br ab tk tgt off hlt stl | pc busy done cnt
    add(1,0,0,0,0,   0,6'd0,     0,0,    0,0,0,0);
    add(0,1,0,0,0,   0,6'd0,     0,0,    0,1,0,0);
    for (int i = 1; i <= 5; i++) add(0,1,0,0,0,0,6'd0,0,0, i,1,0,i);
    add(0,1,1,1,1,  20,6'd0,     0,0,   20,1,0,6);
    add(0,1,1,1,1, 300,6'd0,     0,0,  300,1,0,7);
    add(0,1,1,0,1,   0,6'b111100,0,0,  296,1,0,8);
    add(0,1,1,0,0,   0,6'b111100,0,0,  297,1,0,9);
    add(0,1,1,1,1,1023,6'd0,     0,0, 1023,1,0,10);
    add(0,1,0,0,0,   0,6'd0,     0,0,    0,1,0,11);
    add(0,1,1,1,1,   2,6'd0,     0,0,    2,1,0,12);
    add(0,1,1,0,1,   0,6'b111000,0,0, 1018,1,0,13);
    add(0,1,1,0,1,   0,6'd0,     0,0, 1018,1,0,14);
    add(0,1,1,1,1,   7,6'd0,     0,0,    7,1,0,15);
    for (int i = 0; i < 3; i++) add(0,1,1,1,1,99,6'd0,1,1, 7,1,0,16+i);
    add(0,1,0,0,0,   0,6'd0,     1,0,    7,0,1,19);
    for (int i = 0; i < 4; i++) add(0,1,0,0,0,0,6'd0,0,0, 7,0,1,19);
    add(0,0,0,0,0,   0,6'd0,     0,0,    7,0,0,19);
    add(0,0,0,0,0,   0,6'd0,     0,0,    7,0,0,19);
    add(0,1,0,0,0,   0,6'd0,     0,0,    0,1,0,0);
    add(0,0,0,0,0,   0,6'd0,     0,0,    1,1,0,1);
    add(0,0,1,1,1,  50,6'd0,     0,0,   50,1,0,2);
    add(1,1,1,1,1,  60,6'd0,     0,0,    0,0,0,0);

    @(negedge Clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].br, vecs[i].ab, vecs[i].tk,
            vecs[i].tgt, vecs[i].off, vecs[i].hlt, vecs[i].stl);
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_pc", i), int'(ProgCtr), vecs[i].e_pc);
      chk($sformatf("vec%0d_busy", i), int'(Busy), vecs[i].e_busy);
      chk($sformatf("vec%0d_done", i), int'(Done), vecs[i].e_done);
      chk($sformatf("vec%0d_cnt", i), int'(CycleCount), vecs[i].e_cnt);
      chk($sformatf("vec%0d_cnt4", i), int'(CycleCount4), sat(vecs[i].e_cnt, 15));
    end

    // Hand sequence: reset wins while halted with Start held high
    drive(0,1,0,0,0,0,0,0,0); @(posedge Clk); #1;
    drive(0,1,0,0,0,0,0,1,0); @(posedge Clk); #1;
    chk("seq_halt_done", int'(Done), 1);
    drive(1,1,0,0,0,0,0,1,0); @(posedge Clk); #1;
    chk("seq_rst_in_halt_done", int'(Done), 0);
    chk("seq_rst_in_halt_busy", int'(Busy), 0);
    chk("seq_rst_in_halt_pc", int'(ProgCtr), 0);
    drive(0,0,0,0,0,0,0,0,0); @(posedge Clk); #1;
    chk("seq_idle_after_rst_busy", int'(Busy), 0);

    // Randomized run against the behavioural model
    m_pc = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_cnt4 = 0;
    drive(1,0,0,0,0,0,0,0,0);
    model_step();
    @(posedge Clk); #1;
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 299) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 1),
            $urandom_range(0, 2) != 0,
            PCW'($urandom),
            OFFW'($urandom),
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 4) == 0);
      model_step();
      @(posedge Clk); #1;
      chk("rnd_pc", int'(ProgCtr), m_pc);
      chk("rnd_busy", int'(Busy), int'(m_busy));
      chk("rnd_done", int'(Done), int'(m_done));
      chk("rnd_cnt", int'(CycleCount), m_cnt);
      chk("rnd_cnt4", int'(CycleCount4), m_cnt4);
      chk("rnd_busy_done_excl", int'(Busy & Done), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
